// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS stopwatch sequencer with RUN / PAUSED / ADJUST modes
// and blink masks for the field being adjusted.
// Optional feature macro: SW_CLEAR_EN adds the clr_p input (count clear pulse).
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | counting, seconds advance on tick_1hz with carry into minutes
// PAUSED | counts frozen, all ticks ignored
// ADJUST | selected field advances on tick_2hz, blink phase on tick_5hz
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59,
  parameter int CW      = 6
) (
  input  logic          master_clk,
  input  logic          rst_n,
  input  logic          tick_1hz,
  input  logic          tick_2hz,
  input  logic          tick_5hz,
  input  logic          pause_p,
  input  logic          adj,
  input  logic          sel,
`ifdef SW_CLEAR_EN
  input  logic          clr_p,
`endif
  output logic [CW-1:0] minutes,
  output logic [CW-1:0] seconds,
  output logic [1:0]    mode,
  output logic          blank_min,
  output logic          blank_sec
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSED = 2'b01,
    ADJUST = 2'b10
  } state_t;

  localparam logic [CW-1:0] MAX_MIN_C = CW'(MAX_MIN);
  localparam logic [CW-1:0] MAX_SEC_C = CW'(MAX_SEC);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] min_q, min_d;
  logic [CW-1:0] sec_q, sec_d;
  logic          pause_q, pause_d;
  logic          phase_q, phase_d;
  logic          sel_q;
  logic          blank_min_q, blank_min_d;
  logic          blank_sec_q, blank_sec_d;
  logic          clr;

`ifdef SW_CLEAR_EN
  assign clr = clr_p;
`else
  assign clr = 1'b0;
`endif

  // Next-state, count and blink logic; counts act on the mode registered at this edge.
  always_comb begin
    pause_d     = pause_q ^ pause_p;
    state_d     = RUN;
    min_d       = min_q;
    sec_d       = sec_q;
    phase_d     = phase_q;
    blank_min_d = 1'b0;
    blank_sec_d = 1'b0;

    if (adj)          state_d = ADJUST;
    else if (pause_d) state_d = PAUSED;

    if (clr) begin
      min_d = '0;
      sec_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (tick_1hz) begin
            if (sec_q == MAX_SEC_C) begin
              sec_d = '0;
              min_d = (min_q == MAX_MIN_C) ? '0 : min_q + ONE_C;
            end else begin
              sec_d = sec_q + ONE_C;
            end
          end
        end
        ADJUST: begin
          if (tick_2hz) begin
            if (sel_q) sec_d = (sec_q == MAX_SEC_C) ? '0 : sec_q + ONE_C;
            else       min_d = (min_q == MAX_MIN_C) ? '0 : min_q + ONE_C;
          end
        end
        default: ;
      endcase
    end

    // Phase restarts dark-off on every entry so the first blink is predictable.
    if (state_d == ADJUST && state_q != ADJUST) phase_d = 1'b0;
    else if (state_q == ADJUST && tick_5hz)     phase_d = ~phase_q;

    // Blanks follow the registered sel (sel_q takes 'sel' at this same edge).
    blank_min_d = (state_d == ADJUST) & ~sel & phase_d;
    blank_sec_d = (state_d == ADJUST) &  sel & phase_d;
  end

  // State and datapath registers.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      min_q       <= '0;
      sec_q       <= '0;
      pause_q     <= 1'b0;
      phase_q     <= 1'b0;
      sel_q       <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      pause_q     <= pause_d;
      phase_q     <= phase_d;
      sel_q       <= sel;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign mode      = state_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;

endmodule
